// File: rtl/c_ram_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : c_ram_write_arbiter_if
// Purpose  : Bundles the two producer-lane valid/ready handshakes and the
//            dual-port C-matrix RAM write bus used by c_ram_write_arbiter.
// Ports    : req0_* / req1_* : lane valid, ready, element address, signed data
//            ram_addr1/2, ram_data1/2, ram_write_en : registered RAM write bus
// Modports : slave  - the arbiter (consumes requests, drives the RAM bus)
//            master - the producer / RAM side (drives requests)
// Revision : 1.0 - initial release
// ============================================================================
interface c_ram_write_arbiter_if #(
    parameter int DATA_W = 19,
    parameter int ADDR_W = 6
);
    // Producer lane 0
    logic                     req0_valid;
    logic                     req0_ready;
    logic [ADDR_W-1:0]        req0_addr;
    logic signed [DATA_W-1:0] req0_data;

    // Producer lane 1
    logic                     req1_valid;
    logic                     req1_ready;
    logic [ADDR_W-1:0]        req1_addr;
    logic signed [DATA_W-1:0] req1_data;

    // RAM write bus (two address/data ports, one shared enable)
    logic [ADDR_W-1:0]        ram_addr1;
    logic signed [DATA_W-1:0] ram_data1;
    logic [ADDR_W-1:0]        ram_addr2;
    logic signed [DATA_W-1:0] ram_data2;
    logic                     ram_write_en;

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready,
        output ram_addr1, ram_data1, ram_addr2, ram_data2, ram_write_en
    );

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready,
        input  ram_addr1, ram_data1, ram_addr2, ram_data2, ram_write_en
    );
endinterface
`default_nettype wire

// File: rtl/c_ram_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : c_ram_write_arbiter
// Purpose  : Write controller in front of the dual-port C-matrix result RAM.
//            Accepts results from two producer lanes, maps them onto the two
//            RAM write ports, serialises same-address collisions round-robin,
//            and tracks which elements of the frame have been written.
// Ports    : clk           - system clock, rising edge
//            rst           - synchronous active-high reset
//            start         - one-cycle pulse, begins a new frame
//            bus           - lane handshakes + registered RAM write bus
//            count         - distinct elements written this frame
//            busy          - frame collection in progress
//            done          - every element of the frame has been written
//            overwrite_err - sticky, an already-written element was rewritten
// Revision : 1.0 - initial release
// ============================================================================
module c_ram_write_arbiter #(
    parameter int DATA_W = 19,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64   // must equal 2**ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    c_ram_write_arbiter_if.slave bus,
    output logic [ADDR_W:0]      count,
    output logic                 busy,
    output logic                 done,
    output logic                 overwrite_err
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               rr_ptr;
    logic               rr_ptr_next;

    logic [DEPTH-1:0]   bitmap;
    logic [DEPTH-1:0]   bitmap_next;
    logic [ADDR_W:0]    count_next;
    logic               err_next;

    logic               collision;
    logic               acc0;
    logic               acc1;
    logic               hit0;
    logic               hit1;
    logic               new0;
    logic               new1;

    // ------------------------------------------------------------------
    // Grant logic. Readiness never depends on whether the lane is still
    // holding its request from an earlier cycle, so a lane that loses
    // arbitration is free to withdraw or change its request.
    // ------------------------------------------------------------------
    assign collision = bus.req0_valid && bus.req1_valid &&
                       (bus.req0_addr == bus.req1_addr);

    always_comb begin
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        rr_ptr_next    = rr_ptr;
        // The start cycle itself accepts nothing: the frame is being cleared.
        if (state == ST_COLLECT && !start) begin
            if (collision) begin
                bus.req0_ready = ~rr_ptr;
                bus.req1_ready = rr_ptr;
                // Pointer only moves when it actually arbitrated something.
                rr_ptr_next    = ~rr_ptr;
            end else begin
                bus.req0_ready = 1'b1;
                bus.req1_ready = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame bookkeeping: bitmap of written elements, distinct count and
    // the overwrite flag, all evaluated against the bitmap as it stood at
    // the start of the cycle.
    // ------------------------------------------------------------------
    always_comb begin
        acc0        = bus.req0_valid & bus.req0_ready;
        acc1        = bus.req1_valid & bus.req1_ready;
        hit0        = bitmap[bus.req0_addr];
        hit1        = bitmap[bus.req1_addr];
        new0        = acc0 & ~hit0;
        // Guard against counting one element twice if both lanes were ever
        // accepted on the same address (arbitration prevents this today).
        new1        = acc1 & ~hit1 &
                      ~(acc0 && (bus.req0_addr == bus.req1_addr));
        bitmap_next = bitmap;
        if (acc0) begin
            bitmap_next[bus.req0_addr] = 1'b1;
        end
        if (acc1) begin
            bitmap_next[bus.req1_addr] = 1'b1;
        end
        err_next    = overwrite_err | (acc0 & hit0) | (acc1 & hit1);
        count_next  = count + (ADDR_W+1)'(new0) + (ADDR_W+1)'(new1);
    end

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            rr_ptr <= 1'b0;
        end else begin
            state  <= state_next;
            rr_ptr <= rr_ptr_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                state_next = ST_IDLE;
            end
            ST_COLLECT: begin
                // Leave on the same edge that registers the final write, so
                // the last ram_write_en pulse lines up with done.
                if (count_next == FULL_COUNT) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_DONE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (start) begin
            state_next = ST_COLLECT;
        end
    end

    assign busy = (state == ST_COLLECT);
    assign done = (state == ST_DONE);

    // ------------------------------------------------------------------
    // Bookkeeping registers and registered RAM write bus
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            bitmap           <= '0;
            count            <= '0;
            overwrite_err    <= 1'b0;
            bus.ram_write_en <= 1'b0;
            bus.ram_addr1    <= '0;
            bus.ram_data1    <= '0;
            bus.ram_addr2    <= '0;
            bus.ram_data2    <= '0;
        end else if (start) begin
            bitmap           <= '0;
            count            <= '0;
            overwrite_err    <= 1'b0;
            bus.ram_write_en <= 1'b0;
        end else begin
            bitmap           <= bitmap_next;
            count            <= count_next;
            overwrite_err    <= err_next;
            bus.ram_write_en <= acc0 | acc1;
            if (acc0 && acc1) begin
                bus.ram_addr1 <= bus.req0_addr;
                bus.ram_data1 <= bus.req0_data;
                bus.ram_addr2 <= bus.req1_addr;
                bus.ram_data2 <= bus.req1_data;
            end else if (acc0) begin
                // Single lane drives both ports; a duplicate write to one
                // location is harmless and keeps the enable shared.
                bus.ram_addr1 <= bus.req0_addr;
                bus.ram_data1 <= bus.req0_data;
                bus.ram_addr2 <= bus.req0_addr;
                bus.ram_data2 <= bus.req0_data;
            end else if (acc1) begin
                bus.ram_addr1 <= bus.req1_addr;
                bus.ram_data1 <= bus.req1_data;
                bus.ram_addr2 <= bus.req1_addr;
                bus.ram_data2 <= bus.req1_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_c_ram_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_c_ram_write_arbiter
// Purpose  : Self-checking bench for c_ram_write_arbiter. Expected RAM writes
//            are queued when stimulus is applied and compared one edge later;
//            frame state comes from a small behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_c_ram_write_arbiter;

    localparam int DATA_W = 19;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;

    logic clk;
    logic rst;
    logic start;
    logic [ADDR_W:0] count;
    logic busy;
    logic done;
    logic overwrite_err;

    c_ram_write_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    c_ram_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .bus           (bus),
        .count         (count),
        .busy          (busy),
        .done          (done),
        .overwrite_err (overwrite_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0]        a1;
        logic signed [DATA_W-1:0] d1;
        logic [ADDR_W-1:0]        a2;
        logic signed [DATA_W-1:0] d2;
    } wr_t;

    typedef struct {
        logic                     st;
        logic                     v0;
        logic [ADDR_W-1:0]        a0;
        logic signed [DATA_W-1:0] d0;
        logic                     v1;
        logic [ADDR_W-1:0]        a1;
        logic signed [DATA_W-1:0] d1;
        logic                     er0;
        logic                     er1;
    } vec_t;

    int total = 0;
    int bad   = 0;

    wr_t  sb_q[$];
    vec_t vecs[$];

    // Behavioural model of the frame
    logic [DEPTH-1:0] m_bitmap;
    int               m_count;
    logic             m_err;
    int               m_state;   // 0 idle, 1 collect, 2 done
    wr_t              m_ram;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_bitmap = '0;
        m_count  = 0;
        m_err    = 1'b0;
        m_state  = 0;
        m_ram    = '{'0, '0, '0, '0};
        sb_q.delete();
    endtask

    task automatic check_status(input string tag);
        chk({tag, " count"}, 32'(count), 32'(m_count));
        chk({tag, " overwrite_err"}, 32'(overwrite_err), 32'(m_err));
        chk({tag, " busy"}, 32'(busy), 32'(m_state == 1));
        chk({tag, " done"}, 32'(done), 32'(m_state == 2));
    endtask

    task automatic check_ram(input string tag);
        chk({tag, " ram_addr1"}, 32'(bus.ram_addr1), 32'(m_ram.a1));
        chk({tag, " ram_data1"}, bus.ram_data1, m_ram.d1);
        chk({tag, " ram_addr2"}, 32'(bus.ram_addr2), 32'(m_ram.a2));
        chk({tag, " ram_data2"}, bus.ram_data2, m_ram.d2);
    endtask

    // One clock of stimulus, entered and left just after a falling edge.
    task automatic step(input string tag, input vec_t v);
        logic acc0;
        logic acc1;
        wr_t  w;
        start          = v.st;
        bus.req0_valid = v.v0;
        bus.req0_addr  = v.a0;
        bus.req0_data  = v.d0;
        bus.req1_valid = v.v1;
        bus.req1_addr  = v.a1;
        bus.req1_data  = v.d1;
        #1;
        chk({tag, " req0_ready"}, 32'(bus.req0_ready), 32'(v.er0));
        chk({tag, " req1_ready"}, 32'(bus.req1_ready), 32'(v.er1));
        acc0 = v.v0 & v.er0;
        acc1 = v.v1 & v.er1;
        if (v.st) begin
            m_bitmap = '0;
            m_count  = 0;
            m_err    = 1'b0;
            m_state  = 1;
        end else begin
            if (acc0 && acc1)      sb_q.push_back('{v.a0, v.d0, v.a1, v.d1});
            else if (acc0)         sb_q.push_back('{v.a0, v.d0, v.a0, v.d0});
            else if (acc1)         sb_q.push_back('{v.a1, v.d1, v.a1, v.d1});
            if (acc0) begin
                if (m_bitmap[v.a0]) m_err = 1'b1;
                else begin m_bitmap[v.a0] = 1'b1; m_count++; end
            end
            if (acc1) begin
                if (m_bitmap[v.a1]) m_err = 1'b1;
                else begin m_bitmap[v.a1] = 1'b1; m_count++; end
            end
            if (m_state == 1 && m_count == DEPTH) m_state = 2;
        end
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) begin
            w = sb_q.pop_front();
            chk({tag, " ram_write_en"}, 32'(bus.ram_write_en), 32'd1);
            m_ram = w;
        end else begin
            chk({tag, " ram_write_en"}, 32'(bus.ram_write_en), 32'd0);
        end
        check_ram(tag);
        check_status(tag);
        @(negedge clk);
    endtask

    task automatic add(input logic st, input logic v0, input int a0, input int d0,
                       input logic v1, input int a1, input int d1,
                       input logic er0, input logic er1);
        vec_t v;
        v.st  = st;
        v.v0  = v0;  v.a0 = ADDR_W'(a0);  v.d0 = DATA_W'(d0);
        v.v1  = v1;  v.a1 = ADDR_W'(a1);  v.d1 = DATA_W'(d1);
        v.er0 = er0; v.er1 = er1;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        // Table: collision arbitration, single lane, hold, rewrite, restart.
        //     st v0 a0  d0    v1 a1  d1       er0 er1
        add(1, 1, 5,  100,  1, 5,  -100,    0, 0);  // start cycle: no readies
        add(0, 1, 5,  100,  1, 5,  -100,    1, 0);  // collision, lane 0 wins
        add(0, 1, 5,  100,  1, 5,  -100,    0, 1);  // collision, lane 1 wins, overwrite
        add(0, 0, 0,  0,    1, 63, -262144, 1, 1);  // lane 1 only, extreme data
        add(0, 0, 0,  0,    0, 0,  0,       1, 1);  // nothing valid, ports hold
        add(1, 0, 0,  0,    0, 0,  0,       0, 0);  // restart clears count/err
        add(0, 1, 10, 7,    0, 0,  0,       1, 1);  // write element 10
        add(0, 0, 0,  0,    1, 10, 9,       1, 1);  // rewrite element 10
        add(1, 0, 0,  0,    0, 0,  0,       0, 0);  // restart clears again
        add(0, 1, 20, 1,    1, 20, 2,       1, 0);  // collision, pointer 0
        add(0, 1, 21, 3,    1, 22, 4,       1, 1);  // no collision, pointer kept
        add(0, 1, 23, 5,    1, 23, 6,       0, 1);  // collision, pointer 1
        add(0, 1, 24, 7,    1, 24, 8,       1, 0);  // collision, pointer back to 0

        rst            = 1'b1;
        start          = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req0_addr  = '0;
        bus.req0_data  = '0;
        bus.req1_valid = 1'b0;
        bus.req1_addr  = '0;
        bus.req1_data  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset ram_write_en", 32'(bus.ram_write_en), 32'd0);
        check_ram("reset");
        check_status("reset");
        @(negedge clk);
        rst = 1'b0;

        // IDLE: valid requests are not accepted
        v = '{1'b0, 1'b1, 6'd1, 19'sd1, 1'b1, 6'd2, 19'sd2, 1'b0, 1'b0};
        step("idle", v);

        // Full frame: 32 cycles of two distinct writes
        v = '{1'b1, 1'b1, 6'd0, 19'sd0, 1'b1, 6'd1, 19'sd0, 1'b0, 1'b0};
        step("fill start", v);
        for (int k = 0; k < 32; k++) begin
            v.st  = 1'b0;
            v.v0  = 1'b1; v.a0 = ADDR_W'(2 * k);     v.d0 = DATA_W'(k);
            v.v1  = 1'b1; v.a1 = ADDR_W'(2 * k + 1); v.d1 = DATA_W'(-k);
            v.er0 = 1'b1; v.er1 = 1'b1;
            step($sformatf("fill%0d", k), v);
        end

        // DONE: requests are ignored
        v = '{1'b0, 1'b1, 6'd3, 19'sd3, 1'b1, 6'd4, 19'sd4, 1'b0, 1'b0};
        step("done hold", v);

        foreach (vecs[i]) begin
            step($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset landing on a cycle with an accept: the write is dropped.
        start          = 1'b0;
        rst            = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 6'd30;
        bus.req0_data  = 19'sd3;
        bus.req1_valid = 1'b0;
        #1;
        chk("rst-accept req0_ready", 32'(bus.req0_ready), 32'd1);
        model_reset();
        @(posedge clk);
        #1;
        chk("rst-accept ram_write_en", 32'(bus.ram_write_en), 32'd0);
        check_ram("rst-accept");
        check_status("rst-accept");
        @(negedge clk);
        rst = 1'b0;
        v = '{1'b0, 1'b1, 6'd30, 19'sd3, 1'b1, 6'd31, 19'sd4, 1'b0, 1'b0};
        step("post-rst idle", v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/c_ram_write_arbiter.md
Name: c_ram_write_arbiter

Overview:
- Write controller/arbiter placed in front of the dual-port C-matrix result RAM (64 x 19-bit signed, one shared write enable, two address/data ports).
- Accepts results from two producer lanes through valid/ready handshakes and maps them onto the RAM's two write ports.
- Serialises same-address collisions with round-robin fairness.
- Tracks which of the 64 elements have been written in the current frame; reports done and overwrite errors.

Parameters:
- DATA_W, 19, signed result width
- ADDR_W, 6, element address width
- DEPTH, 64, elements per frame; must equal 2**ADDR_W

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; begins a new frame
- req0_valid  input  1  lane 0 has a result
- req0_ready  output  1  lane 0 result accepted this cycle (combinational)
- req0_addr  input  ADDR_W  lane 0 element index
- req0_data  input  DATA_W  lane 0 signed result
- req1_valid / req1_ready / req1_addr / req1_data  same as lane 0, for lane 1
- ram_addr1  output  ADDR_W  RAM port 1 address (registered)
- ram_data1  output  DATA_W  RAM port 1 data (registered)
- ram_addr2  output  ADDR_W  RAM port 2 address (registered)
- ram_data2  output  DATA_W  RAM port 2 data (registered)
- ram_write_en  output  1  RAM write enable (registered)
- count  output  ADDR_W+1  distinct elements written this frame
- busy  output  1  high in COLLECT
- done  output  1  high in DONE
- overwrite_err  output  1  sticky; an already-written address was accepted again this frame

Behaviour:
- States:
  - IDLE, reset state: both readies 0.
  - COLLECT: accepting results.
  - DONE: both readies 0; held until start or rst.
- Transitions:
  - start in any state -> COLLECT. Clears bitmap, count, overwrite_err. Both readies are 0 in the start cycle.
  - COLLECT -> DONE on the edge where count becomes DEPTH.
- Reset (rst=1 at an edge): state IDLE, rr_ptr=0, bitmap clear. All outputs 0: count, busy, done, overwrite_err, ram_write_en, all ram_addr/ram_data. Any write accepted in the reset cycle is dropped; no ram_write_en follows.
- Readiness in COLLECT, no start:
  - If addresses differ or only one lane is valid: each ready = 1.
  - Collision (both valid, req0_addr == req1_addr): only lane rr_ptr is ready; rr_ptr toggles after the collision cycle.
  - rr_ptr changes only on collision cycles.
- Accept means valid & ready. Latency is exactly one cycle from accept to ram_write_en=1 with the captured address/data.
- RAM port mapping on the next edge:
  - Both accepted: ram_addr1/ram_data1 = lane 0, ram_addr2/ram_data2 = lane 1, ram_write_en=1.
  - One accepted: both ports get that lane's address/data (duplicate write to the same location is benign), ram_write_en=1.
  - None accepted: ram_write_en=0; address/data registers hold their value.
- Bitmap/count:
  - Each accepted address sets its bitmap bit.
  - count increments by the number of newly set bits (0, 1 or 2). It never exceeds DEPTH.
- overwrite_err: set when an accepted address's bit was already set at the start of the cycle. The data is still written (last write wins). Stays set until start or rst.
- The final write's ram_write_en pulse coincides with the first cycle of done=1. done and busy are never both 1.
- Valid/ready: the arbiter makes no assumption that valid is held. A lane not granted may drop or change valid/addr/data freely.

Test Plan:
- rst, start, then 32 cycles of lane0 addr 2k/data k, lane1 addr 2k+1/data -k -> each cycle both ready. Next cycle ram_write_en=1 with matching ports. count=64 after cycle 32; done=1 on the final write cycle; overwrite_err=0.
- Collision: both valid at addr 5 (data 100, -100) for two cycles, rr_ptr=0 -> cycle 1 grants lane 0 only (both ports addr 5/data 100). Cycle 2 grants lane 1 (data -100). overwrite_err=1 after the second accept; count=1.
- Single lane: only req1_valid, addr 63, data -262144 -> ram_addr1=ram_addr2=63, both data -262144, ram_write_en=1 one cycle later, count=1.
- Rewriting addr 10 after writing it -> overwrite_err=1, count unchanged. A later start clears overwrite_err and count to 0.
- rst asserted in the same cycle as an accept -> next cycle ram_write_en=0, state IDLE, both readies 0, all outputs 0.
- In DONE, both lanes valid -> readies stay 0 and no writes occur. start -> COLLECT, busy=1, readies 0 in the start cycle, 1 in the following cycle.
